// File: rtl/cnt_sched_pkg.sv
// ============================================================================
// cnt_sched_pkg : state encoding shared by the interval-timer controller
// Revision 1.0
// ============================================================================
`default_nettype none

package cnt_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/cnt_sched.sv
// ============================================================================
// cnt_sched : interval-timer controller sequencing an external up-counter
// Revision 1.0
// ============================================================================
`default_nettype none

module cnt_sched
   import cnt_sched_pkg::*;
#(
   parameter int N = 8,
   parameter int P = 16
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic         periodic,
   input  logic [P-1:0] prescale,
   input  logic [N-1:0] period,
   input  logic [N-1:0] cnt_q,
   output logic         cnt_en,
   output logic         cnt_clr,
   output logic         busy,
   output logic         tick,
   output logic         done
);

   state_t       state, state_nx;
   logic [P-1:0] pre_q;
   logic [P-1:0] sh_pre;
   logic [N-1:0] sh_per;
   logic         sh_mode;
   logic         step;
   logic         expire;

   assign step   = (state == ST_RUN) && (pre_q == sh_pre);
   assign expire = step && (cnt_q == sh_per);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         pre_q   <= '0;
         sh_pre  <= '0;
         sh_per  <= '0;
         sh_mode <= 1'b0;
      end else begin
         state <= state_nx;
         if (start && !stop) begin
            sh_pre  <= prescale;
            sh_per  <= period;
            sh_mode <= periodic;
         end
         if ((state == ST_RUN) && !step)
            pre_q <= pre_q + 1'b1;
         else
            pre_q <= '0;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_en   = 1'b0;
      cnt_clr  = 1'b0;
      busy     = 1'b0;
      tick     = 1'b0;
      done     = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_clr = 1'b1;
         end
         ST_ARM: begin
            cnt_clr  = 1'b1;
            busy     = 1'b1;
            state_nx = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            // On expiry the clear takes the place of the step, so the counter never wraps.
            cnt_en  = step && !expire;
            tick    = expire;
            cnt_clr = expire;
            if (expire && !sh_mode)
               state_nx = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            cnt_clr = 1'b1;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (start)
         state_nx = ST_ARM;
      if (stop)
         state_nx = ST_IDLE;
   end

endmodule

`default_nettype wire

// File: tb/tb_cnt_sched.sv
// ============================================================================
// tb_cnt_sched : directed self-checking bench for cnt_sched with a counter model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cnt_sched;

   localparam int N = 8;
   localparam int P = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         stop;
   logic         periodic;
   logic [P-1:0] prescale;
   logic [N-1:0] period;
   logic [N-1:0] cnt_q = 8'h5A;
   logic         cnt_en;
   logic         cnt_clr;
   logic         busy;
   logic         tick;
   logic         done;

   int n_checks = 0;
   int n_fail   = 0;
   int max_q;
   logic en_seen;

   cnt_sched #(.N(N), .P(P)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .periodic (periodic),
      .prescale (prescale),
      .period   (period),
      .cnt_q    (cnt_q),
      .cnt_en   (cnt_en),
      .cnt_clr  (cnt_clr),
      .busy     (busy),
      .tick     (tick),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Model of the attached counter: synchronous clear wins over enable.
   always_ff @(posedge clk) begin
      if (cnt_clr)
         cnt_q <= '0;
      else if (cnt_en)
         cnt_q <= cnt_q + 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      if (cnt_en) en_seen = 1'b1;
      if (int'(cnt_q) > max_q) max_q = int'(cnt_q);
   endtask

   // Cycles advanced from the current cycle until tick is seen (bounded).
   task automatic to_tick(input int limit, output int n);
      n = 0;
      while (!tick && n < limit) begin
         cyc();
         n++;
      end
   endtask

   task automatic gap_tick(input int limit, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!tick && n < limit);
   endtask

   task automatic arm(input logic [P-1:0] pre, input logic [N-1:0] per, input logic mode);
      prescale = pre;
      period   = per;
      periodic = mode;
      start    = 1'b1;
      cyc();
      start    = 1'b0;
   endtask

   initial begin
      int n;
      int ticks;
      rst = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0;
      prescale = '0; period = '0;
      max_q = 0; en_seen = 1'b0;
      #2;
      check("rst_cnt_en",  32'(cnt_en),  32'd0);
      check("rst_cnt_clr", 32'(cnt_clr), 32'd1);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_tick",    32'(tick),    32'd0);
      check("rst_done",    32'(done),    32'd0);
      cyc();
      check("rst_cnt_q", 32'(cnt_q), 32'd0);
      rst = 1'b0;
      cyc();

      // One-shot, prescale=1, period=3
      arm(16'd1, 8'd3, 1'b0);
      check("arm_busy",   32'(busy),    32'd1);
      check("arm_clr",    32'(cnt_clr), 32'd1);
      check("arm_en",     32'(cnt_en),  32'd0);
      cyc();
      check("run_busy",   32'(busy),    32'd1);
      to_tick(40, n);
      check("oneshot_lat", 32'(n),       32'd7);
      check("oneshot_q",   32'(cnt_q),   32'd3);
      check("oneshot_clr", 32'(cnt_clr), 32'd1);
      check("oneshot_en",  32'(cnt_en),  32'd0);
      cyc();
      check("done_done", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("done_tick", 32'(tick), 32'd0);
      cyc();
      check("done_hold", 32'(done),  32'd1);
      check("done_q",    32'(cnt_q), 32'd0);

      // Periodic, same settings, restarted from DONE
      arm(16'd1, 8'd3, 1'b1);
      cyc();
      max_q = 0;
      to_tick(40, n);
      check("per_first", 32'(n), 32'd7);
      for (int i = 0; i < 4; i++) begin
         gap_tick(40, n);
         check("per_gap",  32'(n),     32'd8);
         check("per_q",    32'(cnt_q), 32'd3);
      end
      check("per_maxq", 32'(max_q), 32'd3);
      check("per_busy", 32'(busy),  32'd1);

      // Asynchronous reset mid-run
      for (int i = 0; i < 4; i++) cyc();
      check("mid_q_nz", 32'(cnt_q), 32'd1);
      #3 rst = 1'b1;
      #1;
      check("arst_clr",  32'(cnt_clr), 32'd1);
      check("arst_busy", 32'(busy),    32'd0);
      check("arst_tick", 32'(tick),    32'd0);
      check("arst_en",   32'(cnt_en),  32'd0);
      check("arst_done", 32'(done),    32'd0);
      cyc();
      check("arst_q", 32'(cnt_q), 32'd0);
      rst = 1'b0;
      cyc();

      // prescale=0, period=0: tick every RUN cycle, counter never enabled
      arm(16'd0, 8'd0, 1'b1);
      cyc();
      en_seen = 1'b0; max_q = 0; ticks = 0;
      for (int i = 0; i < 6; i++) begin
         if (tick) ticks++;
         cyc();
      end
      check("p0_ticks", 32'(ticks),   32'd6);
      check("p0_en",    32'(en_seen), 32'd0);
      check("p0_maxq",  32'(max_q),   32'd0);

      // stop together with start wins -> IDLE
      start = 1'b1; stop = 1'b1;
      cyc();
      start = 1'b0; stop = 1'b0;
      check("stop_busy", 32'(busy),    32'd0);
      check("stop_tick", 32'(tick),    32'd0);
      check("stop_clr",  32'(cnt_clr), 32'd1);
      cyc();
      check("stop_idle", 32'(busy | done), 32'd0);

      // Mid-run input changes are ignored
      arm(16'd1, 8'd3, 1'b0);
      period = 8'd1; prescale = 16'd0;
      cyc();
      to_tick(40, n);
      check("shadow_lat", 32'(n), 32'd7);
      cyc();

      // Restart during RUN at cnt_q=2
      arm(16'd1, 8'd3, 1'b1);
      cyc();
      n = 0;
      while (cnt_q != 8'd2 && n < 40) begin
         cyc();
         n++;
      end
      check("rs_reach", 32'(n), 32'd4);
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("rs_arm_clr", 32'(cnt_clr), 32'd1);
      check("rs_arm_en",  32'(cnt_en),  32'd0);
      cyc();
      check("rs_run_q", 32'(cnt_q), 32'd0);
      to_tick(40, n);
      check("rs_lat", 32'(n), 32'd7);

      // Full counter range
      arm(16'd0, 8'd255, 1'b0);
      cyc();
      to_tick(300, n);
      check("full_lat", 32'(n),     32'd255);
      check("full_q",   32'(cnt_q), 32'd255);
      cyc();
      check("full_done", 32'(done),  32'd1);
      check("full_wrap", 32'(cnt_q), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
